mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter: the output-direction counterpart of the keypad input peripheral on the CPU's 12-bit address / 16-bit data bus. The CPU stores bytes to a data register; they queue in a 4-entry FIFO and are serialized as 8N1 frames on `tx`. A status register is readable through the top-level read mux, so software can poll for space or completion.

## Interface
Parameters:
- `BASE_ADDR`, 12'hC40, data register address; status register is at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `addr_out`  in  12  CPU address.
- `data_out`  in  16  CPU write data.
- `mem_wrt`  in  1  CPU write strobe, sampled on the rising edge of `clk`.
- `rd_data`  out  16  combinational read data for the top-level mux.
- `tx`  out  1  serial output, registered, idle high.
- `busy`  out  1  high while a frame is shifting or the FIFO is non-empty.

## Operation
- Write to `BASE_ADDR`: push `data_out[7:0]`; `data_out[15:8]` ignored.
- Write to `BASE_ADDR+1` with `data_out[3]=1`: clears the sticky overflow flag. Other bits are ignored.
- Read at `BASE_ADDR+1`: `rd_data` = {9'b0, count[2:0], overflow, shifting, empty, full}.
  - Bit 0: full. Bit 1: empty. Bit 2: shifting. Bit 3: overflow. Bits 6:4: count, 0–4.
- Read at `BASE_ADDR`: `rd_data` = 16'h0000. Any other address: `rd_data` = 16'h0000.
- Reads have no side effects.
- Push while full: data dropped and overflow set. Exception: a pop occurs in the same cycle, in which case the push is accepted and count stays 4.
- Push and pop in the same cycle when not full: both take effect and count is unchanged.
- Frame format: 8N1. Start bit 0, data bits LSB first, stop bit 1.
- Transmit FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: shift out 8 bits, `CLKS_PER_BIT` cycles each; a 3-bit index counts 0..7. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `shifting` = (state != IDLE). `busy` = shifting | !empty.
- Baud counter width is $clog2(CLKS_PER_BIT). It reloads at each bit boundary and holds at zero in IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, FIFO empty (count 0, pointers 0), overflow 0, `rd_data` combinational from that reset state.
- Reset mid-frame: `tx` goes high immediately (asynchronous) and FIFO contents are discarded.
- Push latency: the write at edge N is visible in status at cycle N+1.
- From an empty idle state, a push at edge N causes the pop and IDLE→START at edge N+1. `tx` falls at edge N+2, because `tx` is registered from the state.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles of start+data+stop.
- Back-to-back frames: exactly one IDLE cycle between the end of a stop bit and the next start bit.
- Total per queued byte: 10·`CLKS_PER_BIT`+1 cycles.
- Pointers are 2 bits wide and wrap modulo 4. Count is 3 bits wide.

## Structure
- Shared include `uart_defs.vh`:
  - Register offsets: DATA=0, STAT=1.
  - Status bit indices: FULL, EMPTY, SHIFTING, OVF, COUNT_LSB.
  - FSM state encodings: IDLE, START, DATA, STOP (2-bit).
- Sub-module `sync_fifo4x8`: 4×8 FIFO with push, pop, dout, full, empty, count, and same-cycle push+pop-when-full support.
- Top level remains responsible for muxing `rd_data` into the CPU read path for addresses `BASE_ADDR..BASE_ADDR+1`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `BASE_ADDR`=12'hC40.
- Reset, then read 12'hC41 → `rd_data`=16'h0002 (empty); `tx`=1; `busy`=0.
- Write 16'hAB55 to 12'hC40:
  - `tx` sequence, 4 cycles per bit: 0,1,0,1,0,1,0,1,0,1 (byte 8'h55 LSB first, then stop).
  - `busy` is high for 41 cycles; final status 16'h0002.
- Write 8'h01..8'h05 on consecutive cycles while idle:
  - The first byte pops, so 8'h02..8'h05 fill the FIFO.
  - The fifth write succeeds with no overflow.
  - A sixth write while count=4 → status bit 3 set and the byte is not transmitted.
  - The bench checks the serial bytes 01,02,03,04,05 in order, with a 1-cycle idle gap between frames.
- With overflow set, write 16'h0008 to 12'hC41 → status bit 3 clears; other fields unchanged.
- Assert `rst` mid-DATA bit 3 → `tx`=1 in the same cycle, status 16'h0002, and no further start bit appears.
- Reads and writes to 12'hC42 and 12'h000 → `rd_data`=0 and no FIFO or flag change.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Register offsets relative to BASE_ADDR (data / status).
//   - Bit positions inside the status word.
//   - Transmit FSM state encoding.
//   - pack_status(): builds the 16-bit status word from its fields.
package mmio_uart_tx_pkg;

    localparam int unsigned REG_DATA       = 0;
    localparam int unsigned REG_STAT       = 1;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_SHIFTING  = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_COUNT_LSB = 4;

    // Writing a 1 to this bit of the status register clears overflow.
    localparam int unsigned STAT_OVF_CLEAR = STAT_OVF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       shifting,
        input logic       ovf,
        input logic [2:0] count
    );
        logic [15:0] s;
        s                        = '0;
        s[STAT_FULL]             = full;
        s[STAT_EMPTY]            = empty;
        s[STAT_SHIFTING]         = shifting;
        s[STAT_OVF]              = ovf;
        s[STAT_COUNT_LSB +: 3]   = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo4x8.sv
// 4-entry x 8-bit synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties FIFO)
//   push, din       write request and data
//   pop             read request; dout always shows the head entry
//   full, empty     occupancy flags
//   count           number of stored entries, 0..4
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped (the caller flags the overflow).
module sync_fifo4x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    logic [7:0] mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_reg == 3'd4);
    assign empty   = (count_reg == 3'd0);
    assign count   = count_reg;
    assign pop_ok  = pop && !empty;
    // When full, the slot being vacated by the pop is the one written.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr_reg];

    // Storage needs no reset: pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + {2'b00, push_ok} - {2'b00, pop_ok};
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the 12-bit address / 16-bit data bus.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   addr_out    CPU address
//   data_out    CPU write data
//   mem_wrt     CPU write strobe
//   rd_data     combinational read data (status at BASE_ADDR+1, else 0)
//   tx          registered serial output, idle high
//   busy        frame in progress or bytes queued
// Bytes written to BASE_ADDR are queued in a 4-deep FIFO and sent LSB first.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR    = 12'hC40,
    parameter int          CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr_out,
    input  logic [15:0] data_out,
    input  logic        mem_wrt,
    output logic [15:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [11:0] DATA_ADDR = BASE_ADDR + 12'(REG_DATA);
    localparam logic [11:0] STAT_ADDR = BASE_ADDR + 12'(REG_STAT);

    tx_state_e     state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          ovf_reg;

    logic          wr_data;
    logic          wr_stat;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [2:0]    fifo_count;
    logic          shifting;

    // Only bit 3 of a status write and the low byte of a data write matter.
    logic          unused_data_bits;
    assign unused_data_bits = ^{data_out[15:STAT_OVF_CLEAR+1], data_out[STAT_OVF_CLEAR-1:0]};

    assign wr_data = mem_wrt && (addr_out == DATA_ADDR);
    assign wr_stat = mem_wrt && (addr_out == STAT_ADDR);

    sync_fifo4x8 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .din   (data_out[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign shifting = (state_reg != ST_IDLE);
    assign busy     = shifting || !fifo_empty;
    assign tx       = tx_reg;

    // Sticky overflow: set when a push is dropped, cleared by software.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_data && fifo_full && !fifo_pop) begin
            ovf_reg <= 1'b1;
        end else if (wr_stat && data_out[STAT_OVF_CLEAR]) begin
            ovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    // baud_reg counts down from BAUD_MAX; zero marks the last cycle of a bit.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    baud_next  = BAUD_MAX;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_reg == '0) begin
                    baud_next    = BAUD_MAX;
                    bit_idx_next = 3'd0;
                    state_next   = ST_DATA;
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_MAX;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // tx follows the current state one cycle later, so it is glitch-free.
    always_comb begin
        tx_next = 1'b1;
        case (state_reg)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_reg[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = 16'h0000;
        if (addr_out == STAT_ADDR) begin
            rd_data = pack_status(fifo_full, fifo_empty, shifting, ovf_reg, fifo_count);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [11:0] BASE  = 12'hC40;
    localparam logic [11:0] STAT  = 12'hC41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr_out = STAT;
    logic [15:0] data_out = 16'h0000;
    logic        mem_wrt = 1'b0;
    logic [15:0] rd_data;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Serial line history, one sample per clock (taken at the falling edge).
    logic       tx_hist[$];
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];
    int         dec_ferr;

    always #5 clk = ~clk;
    always @(negedge clk) tx_hist.push_back(tx);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr_out (addr_out),
        .data_out (data_out),
        .mem_wrt  (mem_wrt),
        .rd_data  (rd_data),
        .tx       (tx),
        .busy     (busy)
    );

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge right after it.
    task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
        addr_out = a;
        data_out = d;
        mem_wrt  = 1'b1;
        @(negedge clk);
        mem_wrt  = 1'b0;
        addr_out = STAT;
        data_out = 16'h0000;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_reg(input logic [11:0] a, output logic [15:0] v);
        addr_out = a;
        #1;
        v = rd_data;
        addr_out = STAT;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b still set after %0d cycles, want 0", tag, busy, budget);
        end
    endtask

    // Decode 8N1 frames from history samples [from, to), sampling mid-bit.
    task automatic decode(input int from, input int to);
        int i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        dec_ferr = 0;
        i = from + 1;
        while (i + FRAME <= to) begin
            if (tx_hist[i-1] === 1'b1 && tx_hist[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = tx_hist[i + CPB*(j+1) + CPB/2];
                if (tx_hist[i + CPB*9 + CPB/2] !== 1'b1) dec_ferr++;
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                $display("frame byte=%h at sample %0d", b, i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] v;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_status: got %h want 0002", v); end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        read_reg(BASE, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_data_read: got %h want 0000", v); end
        @(negedge clk);
    endtask

    // Exact cycle-by-cycle tx waveform and busy length for one byte.
    task automatic test_single(input logic [15:0] d);
        int          busy_cycles = 0;
        int          bad = 0;
        logic        exp;
        logic [9:0]  frame;
        logic [15:0] v;
        frame = {1'b1, d[7:0], 1'b0};
        bus_write(BASE, d);
        for (int k = 0; k < 50; k++) begin
            #1;
            exp = (k >= 2 && k < 2 + FRAME) ? frame[(k-2)/CPB] : 1'b1;
            n_checks++;
            if (tx !== exp) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL single_tx: cycle %0d got %b want %b", k, tx, exp);
            end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_cycles !== FRAME + 1) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d want %0d", busy_cycles, FRAME + 1);
        end
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL single_final_status: got %h want 0002", v); end
        @(negedge clk);
    endtask

    // Five back-to-back bytes, a dropped sixth, overflow clear, serial order.
    task automatic test_burst;
        int          from;
        logic [15:0] v;
        from = tx_hist.size();
        for (int b = 1; b <= 5; b++) begin
            bus_write(BASE, {8'($urandom), 8'(b)});
            if (b == 1) begin
                read_reg(STAT, v);
                n_checks++;
                if (v !== 16'h0010) begin n_fail++; $display("FAIL burst_push_latency: got %h want 0010", v); end
            end
        end
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0045) begin n_fail++; $display("FAIL burst_full_no_ovf: got %h want 0045", v); end
        bus_write(BASE, 16'h0006);
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h004D) begin n_fail++; $display("FAIL burst_overflow: got %h want 004D", v); end
        bus_write(STAT, 16'h0008);
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0045) begin n_fail++; $display("FAIL burst_ovf_clear: got %h want 0045", v); end
        wait_idle(6 * (FRAME + 1), "burst");
        idle(5);
        decode(from, tx_hist.size());
        n_checks++;
        if (dec_bytes.size() !== 5) begin
            n_fail++;
            $display("FAIL burst_frame_count: got %0d want 5", dec_bytes.size());
        end
        for (int i = 0; i < dec_bytes.size() && i < 5; i++) begin
            n_checks++;
            if (dec_bytes[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL burst_byte%0d: got %h want %h", i, dec_bytes[i], 8'(i + 1));
            end
            if (i > 0) begin
                n_checks++;
                if (dec_starts[i] - dec_starts[i-1] !== FRAME + 1) begin
                    n_fail++;
                    $display("FAIL burst_spacing%0d: got %0d want %0d", i, dec_starts[i] - dec_starts[i-1], FRAME + 1);
                end
            end
        end
        n_checks++;
        if (dec_ferr !== 0) begin n_fail++; $display("FAIL burst_stop_bits: got %0d bad want 0", dec_ferr); end
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL burst_final_status: got %h want 0002", v); end
        @(negedge clk);
    endtask

    // Random bytes with random spacing, never more than four outstanding.
    task automatic test_random(input int rounds);
        logic [7:0] exp_q[$];
        int         from;
        int         n;
        logic [15:0] d;
        for (int r = 0; r < rounds; r++) begin
            exp_q.delete();
            from = tx_hist.size();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                d = 16'($urandom);
                exp_q.push_back(d[7:0]);
                bus_write(BASE, d);
                idle($urandom_range(0, 50));
            end
            wait_idle(5 * (FRAME + 1), "random");
            idle(3);
            decode(from, tx_hist.size());
            n_checks++;
            if (dec_bytes.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL random_frame_count: got %0d want %0d", dec_bytes.size(), exp_q.size());
            end
            for (int i = 0; i < dec_bytes.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (dec_bytes[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_byte%0d: got %h want %h", i, dec_bytes[i], exp_q[i]);
                end
            end
            n_checks++;
            if (dec_ferr !== 0) begin n_fail++; $display("FAIL random_stop_bits: got %0d bad want 0", dec_ferr); end
        end
    endtask

    // Reset during data bit 3 (driven low) with a second byte still queued.
    task automatic test_reset_mid;
        logic [7:0]  b;
        logic [15:0] v;
        int          from;
        int          lows = 0;
        b = 8'($urandom) & 8'hF7;
        bus_write(BASE, {8'h00, b});
        bus_write(BASE, 16'($urandom));
        idle(18);
        #2;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL resetmid_bit3: got %b want 0", tx); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL resetmid_tx_async: got %b want 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL resetmid_busy: got %b want 0", busy); end
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL resetmid_status: got %h want 0002", v); end
        @(negedge clk);
        rst = 1'b0;
        from = tx_hist.size();
        idle(60);
        for (int i = from; i < tx_hist.size(); i++) if (tx_hist[i] !== 1'b1) lows++;
        n_checks++;
        if (lows !== 0) begin n_fail++; $display("FAIL resetmid_no_restart: got %0d low samples want 0", lows); end
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL resetmid_final_status: got %h want 0002", v); end
        @(negedge clk);
    endtask

    // Unmapped addresses: read as zero, writes change nothing (overflow held).
    task automatic test_other_addr;
        logic [11:0] addrs[2];
        logic [15:0] v;
        int          from;
        int          lows = 0;
        addrs[0] = 12'hC42;
        addrs[1] = 12'h000;
        for (int b = 0; b < 6; b++) bus_write(BASE, 16'($urandom));
        for (int i = 0; i < 2; i++) begin
            read_reg(addrs[i], v);
            n_checks++;
            if (v !== 16'h0000) begin n_fail++; $display("FAIL other_read_%h: got %h want 0000", addrs[i], v); end
            bus_write(addrs[i], 16'($urandom) | 16'h0008);
            read_reg(STAT, v);
            n_checks++;
            if (v !== 16'h004D) begin n_fail++; $display("FAIL other_write_%h: status %h want 004D", addrs[i], v); end
        end
        wait_idle(6 * (FRAME + 1), "other");
        bus_write(STAT, 16'h0008);
        read_reg(STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL other_drained_status: got %h want 0002", v); end
        from = tx_hist.size();
        for (int i = 0; i < 2; i++) bus_write(addrs[i], 16'($urandom));
        idle(20);
        for (int i = from; i < tx_hist.size(); i++) if (tx_hist[i] !== 1'b1) lows++;
        n_checks++;
        if (lows !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL other_no_tx: got %0d low samples busy=%b want 0 and 0", lows, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single(16'hAB55);
        test_single(16'($urandom));
        test_burst();
        test_random(3);
        test_reset_mid();
        test_other_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
